// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver FSM encoding, GRB word width and the
// default pulse timing (100 MHz clock) common to the transmitter and receiver.
package ws2812_pkg;

    localparam logic [2:0] ST_SYNC    = 3'd0;
    localparam logic [2:0] ST_WAIT_HI = 3'd1;
    localparam logic [2:0] ST_MEAS_HI = 3'd2;
    localparam logic [2:0] ST_MEAS_LO = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    localparam int GRB_W            = 24;
    localparam int T_THRESH_DEF     = 60;
    localparam int MIN_HIGH_DEF     = 10;
    localparam int MAX_HIGH_DEF     = 120;
    localparam int RESET_CYCLES_DEF = 28000;
    localparam int PIX_W_DEF        = 8;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_MEAS_HI) || (st == ST_MEAS_LO);
    endfunction

endpackage

// File: rtl/ws2812_sync.sv
// 2-FF synchronizer for the asynchronous serial line plus rise/fall detect.
// ds_o lags din_i by 2 cycles; edge strobes are aligned with the new ds_o level.
module ws2812_sync (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic ds_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign ds_o   = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: pulse-width decode into 24-bit GRB words, pixel count, reset-code framing.
// Optional strip-element forwarding on dout when WS2812_RX_PASSTHRU_EN is defined.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int T_THRESH     = T_THRESH_DEF,
    parameter int MIN_HIGH     = MIN_HIGH_DEF,
    parameter int MAX_HIGH     = MAX_HIGH_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int PIX_W        = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [GRB_W-1:0] grb,
    output logic             grb_valid,
    output logic [PIX_W-1:0] pix_idx,
    output logic             frame_done,
    output logic             busy,
    output logic             err,
    output logic             dout
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RST_C   = CNT_W'(RESET_CYCLES);
    localparam logic [4:0]       LAST_BIT = 5'(GRB_W - 1);

    logic ds, rise, fall;

    ws2812_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .din_i  (din),
        .ds_o   (ds),
        .rise_o (rise),
        .fall_o (fall)
    );

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GRB_W-1:0] sh_q, sh_d, sh_new;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [PIX_W-1:0] pixcnt_q, pixcnt_d;
    logic [GRB_W-1:0] grb_q, grb_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
    logic             grb_valid_q, grb_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic             low_done;

    // cnt_q holds the number of cycles ds has spent at its current level
    always_comb begin
        if (rise || fall)        cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 1'b1;
    end

    assign low_done = ~ds & (cnt_d >= RST_C);
    assign sh_new   = {sh_q[GRB_W-2:0], (cnt_q >= THR_C)};

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        bitcnt_d     = bitcnt_q;
        pixcnt_d     = pixcnt_q;
        grb_d        = grb_q;
        pix_idx_d    = pix_idx_q;
        grb_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        case (state_q)
            ST_SYNC: begin
                if (low_done) state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (rise) state_d = ST_MEAS_HI;
            end
            ST_MEAS_HI: begin
                if (cnt_q > MAX_C || (fall && cnt_q < MIN_C)) begin
                    state_d  = ST_ERROR;
                    err_d    = 1'b1;
                    bitcnt_d = '0;
                end else if (fall) begin
                    state_d = ST_MEAS_LO;
                    sh_d    = sh_new;
                    if (bitcnt_q == LAST_BIT) begin
                        grb_d       = sh_new;
                        grb_valid_d = 1'b1;
                        pix_idx_d   = pixcnt_q;
                        pixcnt_d    = pixcnt_q + 1'b1;
                        bitcnt_d    = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            ST_MEAS_LO: begin
                if (rise) begin
                    state_d = ST_MEAS_HI;
                end else if (low_done) begin
                    // a reset code in mid-word drops the partial word but still closes the frame
                    state_d      = ST_WAIT_HI;
                    frame_done_d = 1'b1;
                    pixcnt_d     = '0;
                    bitcnt_d     = '0;
                    if (bitcnt_q != '0) err_d = 1'b1;
                end
            end
            ST_ERROR: begin
                bitcnt_d = '0;
                if (low_done) begin
                    state_d  = ST_WAIT_HI;
                    pixcnt_d = '0;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            cnt_q        <= '0;
            sh_q         <= '0;
            bitcnt_q     <= '0;
            pixcnt_q     <= '0;
            grb_q        <= '0;
            pix_idx_q    <= '0;
            grb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            bitcnt_q     <= bitcnt_d;
            pixcnt_q     <= pixcnt_d;
            grb_q        <= grb_d;
            pix_idx_q    <= pix_idx_d;
            grb_valid_q  <= grb_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign grb        = grb_q;
    assign grb_valid  = grb_valid_q;
    assign pix_idx    = pix_idx_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign busy       = is_busy(state_q);

`ifdef WS2812_RX_PASSTHRU_EN
    logic arm_q, fwd_q, dout_q, stop;

    // forwarding begins on the first rising edge after the frame's own pixel was captured
    assign stop = frame_done_d | ((state_d == ST_ERROR) && (state_q != ST_ERROR));

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            arm_q  <= 1'b0;
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            if (grb_valid_q && pix_idx_q == '0) arm_q <= 1'b1;
            if (arm_q && rise) begin
                fwd_q <= 1'b1;
                arm_q <= 1'b0;
            end
            dout_q <= (fwd_q | (arm_q & rise)) & ds;
        end
    end

    assign dout = dout_q;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: pixel scoreboard, width table, error and reset corner cases.
module tb_ws2812_rx;

    localparam int RST = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        din = 1'b0;
    logic [23:0] grb;
    logic        grb_valid;
    logic [7:0]  pix_idx;
    logic        frame_done;
    logic        busy;
    logic        err;
    logic        dout;

    always #5 clk = ~clk;

    ws2812_rx #(
        .T_THRESH(60), .MIN_HIGH(10), .MAX_HIGH(120), .RESET_CYCLES(RST), .PIX_W(8)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .grb(grb), .grb_valid(grb_valid),
        .pix_idx(pix_idx), .frame_done(frame_done), .busy(busy), .err(err), .dout(dout)
    );

    typedef struct packed { logic [23:0] grb; logic [7:0] idx; } exp_t;
    typedef struct { logic [23:0] w; logic [7:0] idx; bit eof; } pix_vec_t;
    typedef struct { int hi; logic [23:0] exp; } wid_vec_t;

    exp_t     exp_q[$];
    exp_t     e;
    int       n_chk = 0;
    int       n_pass = 0;
    int       fd_cnt = 0;
    int       dout_bad = 0;
    bit       mirror_mode = 1'b0;
    logic [2:0] din_h = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) din_h <= {din_h[1:0], din};

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (mirror_mode ? (dout !== din_h[2]) : (dout !== 1'b0)) dout_bad++;
        if (grb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("grb_valid with empty scoreboard", 32'(grb_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pixel grb", 32'(grb), 32'(e.grb));
                check("pixel idx", 32'(pix_idx), 32'(e.idx));
            end
        end
    end

    task automatic push(input logic [23:0] g, input logic [7:0] i);
        exp_q.push_back(exp_t'{grb: g, idx: i});
    endtask

    task automatic bit_pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // sp_idx selects one bit position sent with a custom high width (sp_hi)
    task automatic send_word(input logic [23:0] w, input int sp_idx, input int sp_hi);
        for (int i = 23; i >= 0; i--) begin
            int hi, lo;
            if (i == sp_idx) begin
                hi = sp_hi;
                lo = (125 - sp_hi < 40) ? 40 : 125 - sp_hi;
            end else if (w[i]) begin
                hi = 80; lo = 45;
            end else begin
                hi = 40; lo = 85;
            end
            bit_pulse(hi, lo);
        end
    endtask

    task automatic end_frame(input int fd_inc, input string tag);
        int fd0;
        fd0 = fd_cnt;
        din = 1'b0;
        repeat (RST + 10) @(negedge clk);
        check({tag, " frame_done count"}, 32'(fd_cnt), 32'(fd0 + fd_inc));
        check({tag, " pixels drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        din = 1'b0;
        repeat (RST + 10) @(negedge clk);
    endtask

    pix_vec_t ptab[4];
    wid_vec_t wtab[6];

    initial begin
        ptab[0] = '{24'h123456, 8'd0, 1'b0};
        ptab[1] = '{24'hABCDEF, 8'd1, 1'b0};
        ptab[2] = '{24'h000001, 8'd2, 1'b1};
        ptab[3] = '{24'h0F0F0F, 8'd0, 1'b1};
        wtab[0] = '{40,  24'h5A5A5A};
        wtab[1] = '{80,  24'h5A5A5B};
        wtab[2] = '{60,  24'h5A5A5B};
        wtab[3] = '{59,  24'h5A5A5A};
        wtab[4] = '{10,  24'h5A5A5A};
        wtab[5] = '{120, 24'h5A5A5B};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset grb", 32'(grb), 32'd0);
        check("reset grb_valid", 32'(grb_valid), 32'd0);
        check("reset pix_idx", 32'(pix_idx), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        reset = 1'b0;
        repeat (RST + 10) @(negedge clk);

        // single pixel frame
        push(24'hFF0000, 8'd0);
        send_word(24'hFF0000, -1, 0);
        check("busy mid-frame", 32'(busy), 32'd1);
        end_frame(1, "t1");
        check("t1 err", 32'(err), 32'd0);
        check("t1 busy idle", 32'(busy), 32'd0);
        check("t1 grb hold", 32'(grb), 32'hFF0000);

        // back-to-back pixels, then a new frame restarting at index 0
        for (int i = 0; i < 4; i++) begin
            push(ptab[i].w, ptab[i].idx);
            send_word(ptab[i].w, -1, 0);
            if (ptab[i].eof) end_frame(1, "pix table");
        end

        // width classification on bit 0 of each pixel in one frame
        for (int i = 0; i < 6; i++) begin
            push(wtab[i].exp, 8'(i));
            send_word(24'h5A5A5A, 0, wtab[i].hi);
        end
        end_frame(1, "widths");
        check("widths err", 32'(err), 32'd0);

        // reset in the middle of bit 17, then data without a reset code is ignored
        push(24'hC0FFEE, 8'd0);
        send_word(24'hC0FFEE, -1, 0);
        for (int i = 0; i < 16; i++) bit_pulse(80, 45);
        din = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset grb", 32'(grb), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset pix_idx", 32'(pix_idx), 32'd0);
        check("midreset err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        din = 1'b0;
        repeat (85) @(negedge clk);
        send_word(24'h777777, -1, 0);
        end_frame(0, "unsynced");
        push(24'h3C3C3C, 8'd0);
        send_word(24'h3C3C3C, -1, 0);
        end_frame(1, "after reset");

`ifdef WS2812_RX_PASSTHRU_EN
        push(24'hA5A5A5, 8'd0);
        send_word(24'hA5A5A5, -1, 0);
        mirror_mode = 1'b1;
        push(24'h5A0F33, 8'd1);
        send_word(24'h5A0F33, -1, 0);
        end_frame(1, "passthru");
        mirror_mode = 1'b0;
        push(24'hFFFFFF, 8'd0);
        send_word(24'hFFFFFF, -1, 0);
        end_frame(1, "passthru next");
        check("passthru err", 32'(err), 32'd0);
`endif

        // glitch pulse: width 9 on the first bit
        do_reset();
        send_word(24'h123456, 23, 9);
        check("glitch err", 32'(err), 32'd1);
        check("glitch busy", 32'(busy), 32'd0);
        end_frame(0, "glitch");
        push(24'h00FF00, 8'd0);
        send_word(24'h00FF00, -1, 0);
        end_frame(1, "glitch recover");

        // line stuck high for 121 cycles
        do_reset();
        check("err cleared by reset", 32'(err), 32'd0);
        din = 1'b1;
        repeat (121) @(negedge clk);
        din = 1'b0;
        repeat (5) @(negedge clk);
        check("stuck err", 32'(err), 32'd1);
        end_frame(0, "stuck");
        push(24'h814224, 8'd0);
        send_word(24'h814224, -1, 0);
        end_frame(1, "stuck recover");
        check("stuck err sticky", 32'(err), 32'd1);

        // partial word closed by a reset code
        do_reset();
        for (int i = 0; i < 12; i++) bit_pulse(80, 45);
        end_frame(1, "partial");
        check("partial err", 32'(err), 32'd1);

        check("dout behaviour", 32'(dout_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receive-side counterpart of the WS2812B GRB transmitter chain: decodes the single-wire NRZ pulse stream back into 24-bit GRB pixel words.
- Classifies each high pulse as 0/1 by width, assembles MSB-first G7..G0 R7..R0 B7..B0 words, counts pixels and detects the >280 us low reset code as end of frame.
- Used as loopback checker for the LED transmitter and as front end for a strip-emulator board.

Parameters:
- T_THRESH, 60, high width in clk cycles at or above which a bit decodes as 1 (100 MHz: T0H=40, T1H=80).
- MIN_HIGH, 10, high pulses shorter than this are glitch errors.
- MAX_HIGH, 120, high pulses longer than this are errors.
- RESET_CYCLES, 28000, low time in clk cycles that constitutes the reset code (280 us at 100 MHz).
- PIX_W, 8, pixel index width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- din  in  1  asynchronous WS2812 serial line
- grb  out  24  last decoded pixel, {G,R,B}
- grb_valid  out  1  one-cycle strobe, grb/pix_idx valid
- pix_idx  out  PIX_W  index of pixel on grb (0 = first after reset code)
- frame_done  out  1  one-cycle strobe on reset-code detection after at least one bit
- busy  out  1  high in MEAS_HI/MEAS_LO
- err  out  1  sticky error flag
- dout  out  1  forwarded stream (see Optional Feature)

Behaviour:
- Clock clk; reset is synchronous, active-high. Reset mid-operation aborts everything: all outputs 0, grb=0, pix_idx=0, bit count=0, state=SYNC.
- din passes a 2-FF synchronizer; all timing is on the synchronized signal ds (2-cycle input latency).
- One counter cnt, width clog2(RESET_CYCLES+1), saturating; cleared on every ds edge.
- States:
  - SYNC: wait for ds low for RESET_CYCLES consecutive cycles, then WAIT_HI. A rising edge restarts the count. No frame_done.
  - WAIT_HI: ds rising edge -> MEAS_HI, cnt=1.
  - MEAS_HI: count while high. cnt > MAX_HIGH -> ERROR. On falling edge: cnt < MIN_HIGH -> ERROR; otherwise shift bit (cnt >= T_THRESH ? 1 : 0) into shift register LSB, bitcnt++, then MEAS_LO.
  - MEAS_LO: rising edge -> MEAS_HI. Low reaching RESET_CYCLES -> WAIT_HI with frame_done pulse.
  - ERROR: set err; discard the partial word; wait for ds low RESET_CYCLES, then WAIT_HI. No frame_done.
- Word complete on the falling edge of the 24th bit: the next cycle, grb <= shift register, grb_valid=1, pix_idx=current pixel counter; then pixel counter++ (wraps modulo 2^PIX_W) and bitcnt=0.
- Boundary cases:
  - High width exactly T_THRESH decodes as 1.
  - Width exactly MIN_HIGH or MAX_HIGH is legal.
  - Reset code with bitcnt != 0: set err, discard the partial word, still pulse frame_done.
  - frame_done clears the pixel counter and bitcnt.
  - grb holds its value between strobes.
- err stays set until reset.
- busy=0 in SYNC, WAIT_HI and ERROR.

Optional Feature:
- Macro WS2812_RX_PASSTHRU_EN.
- Defined: the block acts as a strip element. The first pixel of each frame is consumed (not forwarded). Once that pixel's grb_valid fires, dout mirrors ds delayed 1 cycle, starting from the next rising edge. Forwarding stops at frame_done or on entry to ERROR, with dout=0.
- Not defined: dout tied 0 and no forwarding logic is built.

Decomposition:
- Shared package ws2812_pkg holds the state encoding (SYNC, WAIT_HI, MEAS_HI, MEAS_LO, ERROR), the GRB word width 24, and the default timing constants shared with the transmitter.
- One sub-module, ws2812_sync: 2-FF synchronizer plus rise/fall edge detect.

Test Plan:
- Reset, hold din low 28000 cycles, send 24 bits 0xFF0000 (T1H=80/T1L=45 for 1s, T0H=40/T0L=85 for 0s), then low 28000 -> one grb_valid with grb=0xFF0000, pix_idx=0, then one frame_done, err=0.
- Three pixels 0x123456, 0xABCDEF, 0x000001 back to back -> grb_valid ×3 with pix_idx 0,1,2 and matching grb; next frame restarts at pix_idx 0.
- Bit with high width 60 -> decodes 1; width 59 -> 0; width 10 legal; width 9 -> err=1, no grb_valid until after a 28000-cycle low.
- Line stuck high 121 cycles -> ERROR, err=1; after 28000 low cycles -> WAIT_HI, next valid pixel decodes correctly, err still 1.
- 12 bits then reset code -> frame_done=1, err=1, no grb_valid.
- Assert reset in the middle of bit 17 -> outputs 0, state SYNC; data without a preceding 28000-cycle low is ignored.
- With WS2812_RX_PASSTHRU_EN: 2-pixel frame -> pixel 0 captured, dout reproduces pixel 1's pulses delayed by 3 cycles from din; dout=0 after frame_done.
